// File: rtl/snn_pkg.sv
// Shared SNN datapath package.
// Holds the constant clog2 helper, the accumulator FSM state encoding and the
// default weight/current widths shared by the synaptic and membrane blocks.
package snn_pkg;

  localparam int DEF_W_WIDTH   = 8;
  localparam int DEF_OUT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ACCUM = ST_ACCUM,
    S_DONE  = ST_DONE
  } acc_state_t;

  // Number of bits needed to index v distinct values (clog2(1) = 0).
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_truncate.sv
// Signed width reduction with optional saturation.
// SAT=1: values outside the OUT_W signed range clip to max/min and raise sat.
// SAT=0: plain two's-complement truncation, sat stays 0.
// Ports:
//   in_val  - signed IN_W input
//   out_val - signed OUT_W result
//   sat     - result was clipped
module sat_truncate #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 8,
  parameter bit SAT   = 1'b1
) (
  input  logic signed [IN_W-1:0]  in_val,
  output logic signed [OUT_W-1:0] out_val,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((longint'(1) <<< (OUT_W-1)) - 1);
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(longint'(1) <<< (OUT_W-1)));

  logic                    over, under;
  logic signed [OUT_W-1:0] wrap_v, clip_v;

  assign over   = (in_val > MAX_V);
  assign under  = (in_val < MIN_V);
  assign wrap_v = in_val[OUT_W-1:0];

  always_comb begin
    clip_v = wrap_v;
    if (over)       clip_v = {1'b0, {(OUT_W-1){1'b1}}};
    else if (under) clip_v = {1'b1, {(OUT_W-1){1'b0}}};
  end

  // Both paths are always built so the full input is consumed in either mode.
  assign out_val = SAT ? clip_v : wrap_v;
  assign sat     = SAT & (over | under);

endmodule

// File: rtl/input_current_accumulator.sv
// Multi-cycle synaptic input current accumulator.
// Captures a spike vector and packed weight vector on start, sums the weights
// of active inputs LANES per cycle over M/LANES cycles, then converts the sum
// to a signed OUT_WIDTH current and pulses done.
// Optional feature macro: INPUT_CURRENT_SAT_EN
//   defined   - out-of-range sums saturate and raise saturated
//   undefined - legacy two's-complement wrap, saturated tied to 0
// Ports:
//   clk, reset     - rising-edge clock, asynchronous active-high reset
//   start          - request accumulation (only honoured in IDLE)
//   input_spikes   - M-bit spike vector, bit i gates weight i
//   weights        - M packed signed W_WIDTH weights
//   busy           - high in ACCUM and DONE
//   done           - one-cycle pulse when input_current updates
//   input_current  - signed result, held between done pulses
//   saturated      - result was clipped, held with input_current
// M must be a multiple of LANES and OUT_WIDTH must not exceed ACC_W.
module input_current_accumulator
  import snn_pkg::*;
#(
  parameter int M         = 24,
  parameter int W_WIDTH   = DEF_W_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int LANES     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [M-1:0]                input_spikes,
  input  logic [M*W_WIDTH-1:0]        weights,
  output logic                        busy,
  output logic                        done,
  output logic signed [OUT_WIDTH-1:0] input_current,
  output logic                        saturated
);

  localparam int ACC_W = W_WIDTH + clog2(M) + 1;
  localparam int IDX_W = clog2(M + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M - LANES);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

`ifdef INPUT_CURRENT_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  acc_state_t state, state_nxt;

  logic [M-1:0]                   spk_q;
  logic [M*W_WIDTH-1:0]           w_q;
  logic signed [ACC_W-1:0]        acc;
  logic [IDX_W-1:0]               idx;
  logic [LANES-1:0][ACC_W-1:0]    lane_val;
  logic [ACC_W-1:0]               lane_sum;
  logic                           last;
  logic signed [OUT_WIDTH-1:0]    conv_val;
  logic                           conv_sat;

  // The captured vectors are shifted down each ACCUM cycle, so the lanes
  // always read the low LANES entries instead of muxing on idx.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_val[k] = spk_q[k]
      ? {{(ACC_W-W_WIDTH){w_q[k*W_WIDTH+W_WIDTH-1]}}, w_q[k*W_WIDTH +: W_WIDTH]}
      : '0;
  end

  // Same-width modular add is exact for two's complement; ACC_W is wide
  // enough that the full M-input sum never overflows.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) lane_sum = lane_sum + lane_val[k];
  end

  assign last = (idx == LAST_IDX);
  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ACCUM;
      S_ACCUM: if (last)  state_nxt = S_DONE;
      S_DONE:             state_nxt = S_IDLE;
      default:            state_nxt = S_IDLE;
    endcase
  end

  sat_truncate #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_WIDTH),
    .SAT   (SAT_EN)
  ) u_conv (
    .in_val  (acc),
    .out_val (conv_val),
    .sat     (conv_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      spk_q         <= '0;
      w_q           <= '0;
      acc           <= '0;
      idx           <= '0;
      done          <= 1'b0;
      input_current <= '0;
      saturated     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            spk_q <= input_spikes;
            w_q   <= weights;
            acc   <= '0;
            idx   <= '0;
          end
        end
        S_ACCUM: begin
          acc   <= acc + signed'(lane_sum);
          idx   <= idx + IDX_STEP;
          spk_q <= spk_q >> LANES;
          w_q   <= w_q >> (LANES * W_WIDTH);
        end
        S_DONE: begin
          input_current <= conv_val;
          saturated     <= conv_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_input_current_accumulator.sv
// Self-checking bench for input_current_accumulator (default parameters).
// Expected results come from a plain integer sum of active weights followed
// by range clipping (or wrapping when INPUT_CURRENT_SAT_EN is undefined).
module tb_input_current_accumulator;
  localparam int M   = 24;
  localparam int W   = 8;
  localparam int O   = 8;
  localparam int L   = 4;
  localparam int LAT = M / L + 1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [M-1:0]        input_spikes = '0;
  logic [M*W-1:0]      weights = '0;
  logic                busy, done, saturated;
  logic signed [O-1:0] input_current;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  input_current_accumulator #(.M(M), .W_WIDTH(W), .OUT_WIDTH(O), .LANES(L)) dut (
    .clk(clk), .reset(reset), .start(start), .input_spikes(input_spikes),
    .weights(weights), .busy(busy), .done(done), .input_current(input_current),
    .saturated(saturated)
  );

  // ---------------- reference model ----------------
  function automatic int model_sum(input logic [M-1:0] s, input logic [M*W-1:0] w);
    int sum;
    logic signed [W-1:0] wi;
    sum = 0;
    for (int i = 0; i < M; i++) begin
      wi = w[i*W +: W];
      if (s[i]) sum += int'(wi);
    end
    return sum;
  endfunction

  function automatic logic signed [O-1:0] model_cur(input int sum);
    logic [31:0] raw;
    int hi, lo;
    raw = sum;
    hi = (1 << (O-1)) - 1;
    lo = -(1 << (O-1));
`ifdef INPUT_CURRENT_SAT_EN
    if (sum > hi) return O'(hi);
    if (sum < lo) return O'(lo);
`endif
    return raw[O-1:0];
  endfunction

  function automatic logic model_sat(input int sum);
`ifdef INPUT_CURRENT_SAT_EN
    return (sum > (1 << (O-1)) - 1) || (sum < -(1 << (O-1)));
`else
    return (sum != sum + 1) && 1'b0;
`endif
  endfunction

  function automatic logic [M*W-1:0] rand_w();
    logic [M*W-1:0] r;
    for (int i = 0; i < M; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  function automatic logic [M*W-1:0] fill_w(input logic [W-1:0] v);
    logic [M*W-1:0] r;
    for (int i = 0; i < M; i++) r[i*W +: W] = v;
    return r;
  endfunction

  logic [M-1:0]   c2_s;
  logic [M*W-1:0] c2_w;

  // Pulses start for edge 0, scrambles the inputs every cycle afterwards and
  // reports the edge on which done was seen plus whether busy tracked it.
  task automatic do_op(input logic [M-1:0] s, input logic [M*W-1:0] w,
                       output int lat, output logic signed [O-1:0] cur,
                       output logic sat, output bit busy_ok);
    @(negedge clk);
    input_spikes = s; weights = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; cur = '0; sat = 1'b0;
    busy_ok = (busy === 1'b1);
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      input_spikes = M'($urandom); weights = rand_w();
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n; cur = input_current; sat = saturated;
        busy_ok &= (busy === 1'b0);
      end else begin
        busy_ok &= (busy === 1'b1);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    ntotal++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else npass++;
    ntotal++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else npass++;
    ntotal++; if (input_current !== '0) $display("FAIL reset_cur: got %0d want 0", input_current); else npass++;
    ntotal++; if (saturated !== 1'b0) $display("FAIL reset_sat: got %b want 0", saturated); else npass++;
    reset = 1'b0;
  endtask

  task automatic test_zero_spikes();
    int lat; logic signed [O-1:0] cur; logic sat; bit bok;
    do_op('0, rand_w(), lat, cur, sat, bok);
    ntotal++; if (lat != LAT) $display("FAIL zero_latency: got %0d want %0d", lat, LAT); else npass++;
    ntotal++; if (!bok) $display("FAIL zero_busy: busy profile wrong, want high edges 1-%0d", LAT); else npass++;
    ntotal++; if (cur !== 0) $display("FAIL zero_cur: got %0d want 0", cur); else npass++;
    ntotal++; if (sat !== 1'b0) $display("FAIL zero_sat: got %b want 0", sat); else npass++;
    @(negedge clk);
    ntotal++; if (done !== 1'b0) $display("FAIL done_pulse_width: got %b want 0", done); else npass++;
    ntotal++; if (input_current !== 0) $display("FAIL cur_hold: got %0d want 0", input_current); else npass++;
  endtask

  task automatic test_sparse();
    int lat; logic signed [O-1:0] cur; logic sat; bit bok; int sum;
    do_op(c2_s, c2_w, lat, cur, sat, bok);
    sum = model_sum(c2_s, c2_w);
    ntotal++; if (sum != 27) $display("FAIL sparse_model: got %0d want 27", sum); else npass++;
    ntotal++; if (cur !== model_cur(sum)) $display("FAIL sparse_cur: got %0d want %0d", cur, model_cur(sum)); else npass++;
    ntotal++; if (sat !== 1'b0) $display("FAIL sparse_sat: got %b want 0", sat); else npass++;
    ntotal++; if (lat != LAT || !bok) $display("FAIL sparse_timing: got lat %0d busy_ok %0d want %0d 1", lat, bok, LAT); else npass++;
  endtask

  task automatic test_extremes();
    int lat; logic signed [O-1:0] cur; logic sat; bit bok; int sum;
    logic [M*W-1:0] w;
    w = fill_w(8'd100);
    do_op('1, w, lat, cur, sat, bok);
    sum = model_sum('1, w);
    ntotal++; if (cur !== model_cur(sum)) $display("FAIL allpos_cur: got %0d want %0d", cur, model_cur(sum)); else npass++;
    ntotal++; if (sat !== model_sat(sum)) $display("FAIL allpos_sat: got %b want %b", sat, model_sat(sum)); else npass++;
    w = fill_w(8'h80);
    do_op('1, w, lat, cur, sat, bok);
    sum = model_sum('1, w);
    ntotal++; if (cur !== model_cur(sum)) $display("FAIL allneg_cur: got %0d want %0d", cur, model_cur(sum)); else npass++;
    ntotal++; if (sat !== model_sat(sum)) $display("FAIL allneg_sat: got %b want %b", sat, model_sat(sum)); else npass++;
  endtask

  task automatic test_random();
    int lat; logic signed [O-1:0] cur; logic sat; bit bok; int sum;
    logic [M-1:0] s; logic [M*W-1:0] w;
    for (int t = 0; t < 24; t++) begin
      s = M'($urandom);
      w = rand_w();
      if (t % 4 == 1) begin
        s = '1;
        for (int i = 0; i < M; i++) w[i*W +: W] = W'($urandom_range(2, 12));
      end else if (t % 4 == 2) begin
        for (int i = 0; i < M; i++) w[i*W +: W] = W'(-$urandom_range(2, 12));
      end
      do_op(s, w, lat, cur, sat, bok);
      sum = model_sum(s, w);
      ntotal++;
      if (lat != LAT || !bok || cur !== model_cur(sum) || sat !== model_sat(sum))
        $display("FAIL random_%0d: got cur %0d sat %b lat %0d busy_ok %0d want cur %0d sat %b lat %0d busy_ok 1",
                 t, cur, sat, lat, bok, model_cur(sum), model_sat(sum), LAT);
      else npass++;
    end
  endtask

  task automatic test_start_while_busy();
    int ndone, first; logic signed [O-1:0] cur;
    int lat; logic sat; bit bok;
    logic [M*W-1:0] w1;
    w1 = fill_w(8'd1);
    @(negedge clk);
    input_spikes = c2_s; weights = c2_w; start = 1'b1;
    @(negedge clk);                 // after edge 0
    start = 1'b0;
    @(negedge clk);                 // after edge 1: new vectors sampled at edge 2
    input_spikes = '1; weights = w1; start = 1'b1;
    ndone = 0; first = -1; cur = '0;
    for (int n = 2; n <= 30; n++) begin
      @(negedge clk);               // after edge n
      start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin first = n; cur = input_current; end
      end
    end
    ntotal++; if (ndone != 1) $display("FAIL busy_start_count: got %0d dones want 1", ndone); else npass++;
    ntotal++; if (first != LAT) $display("FAIL busy_start_latency: got %0d want %0d", first, LAT); else npass++;
    ntotal++; if (cur !== 27) $display("FAIL busy_start_cur: got %0d want 27", cur); else npass++;
    do_op('1, w1, lat, cur, sat, bok);
    ntotal++; if (cur !== model_cur(model_sum('1, w1))) $display("FAIL busy_start_next: got %0d want %0d", cur, model_cur(model_sum('1, w1))); else npass++;
  endtask

  task automatic test_reset_mid();
    int ndone; int lat; logic signed [O-1:0] cur; logic sat; bit bok;
    @(negedge clk);
    input_spikes = c2_s; weights = c2_w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);      // after edge 2
    #2 reset = 1'b1;
    #1;
    ntotal++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midreset_ctl: got busy %b done %b want 0 0", busy, done); else npass++;
    ntotal++; if (input_current !== 0) $display("FAIL midreset_cur: got %0d want 0", input_current); else npass++;
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    ntotal++; if (ndone != 0) $display("FAIL midreset_nodone: got %0d dones want 0", ndone); else npass++;
    do_op(c2_s, c2_w, lat, cur, sat, bok);
    ntotal++; if (cur !== 27 || lat != LAT) $display("FAIL midreset_recover: got cur %0d lat %0d want 27 %0d", cur, lat, LAT); else npass++;
  endtask

  task automatic test_back_to_back();
    int ndone, first, second, badv;
    @(negedge clk);
    input_spikes = c2_s; weights = c2_w; start = 1'b1;
    ndone = 0; first = -1; second = -1; badv = 0;
    for (int n = 0; n <= 24; n++) begin
      @(negedge clk);               // after edge n
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = n; else if (second < 0) second = n;
        if (input_current !== 27) badv++;
      end
    end
    start = 1'b0;
    ntotal++; if (first != LAT || second != 2*LAT+1) $display("FAIL b2b_timing: got %0d %0d want %0d %0d", first, second, LAT, 2*LAT+1); else npass++;
    ntotal++; if (ndone != 3) $display("FAIL b2b_count: got %0d want 3", ndone); else npass++;
    ntotal++; if (badv != 0) $display("FAIL b2b_value: got %0d wrong results want 0", badv); else npass++;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    c2_w = fill_w(8'h7F);
    c2_w[0*W +: W]  = 8'd10;
    c2_w[5*W +: W]  = 8'hFD;
    c2_w[23*W +: W] = 8'd20;
    c2_s = '0;
    c2_s[0] = 1'b1; c2_s[5] = 1'b1; c2_s[23] = 1'b1;

    test_reset();
    test_zero_spikes();
    test_sparse();
    test_extremes();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/input_current_accumulator.md
Name: input_current_accumulator

Overview:
Parametrised, multi-cycle successor to the single-cycle synaptic current summer in the SNN neuron datapath. It captures a spike vector and a weight vector on `start`. It then accumulates the weights of active inputs over M/LANES cycles, LANES lanes per cycle. The result is saturated to a signed OUT_WIDTH current and reported with a done pulse. It sits between the spike/delay fabric and the LIF membrane update.

Parameters:
M, 24, number of synaptic inputs; must be a multiple of LANES
W_WIDTH, 8, signed weight width (two's complement)
OUT_WIDTH, 8, signed output current width; must be <= ACC_W
LANES, 4, weights summed per accumulate cycle
ACC_W (localparam), W_WIDTH+clog2(M)+1, internal accumulator width; never overflows

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-high
start  input  1  request a new accumulation; sampled only in IDLE
input_spikes  input  M  spike vector; bit i gates weight i
weights  input  M*W_WIDTH  packed signed weights; weight i = weights[i*W_WIDTH +: W_WIDTH]
busy  output  1  high in ACCUM and DONE states
done  output  1  one-cycle pulse when input_current is updated
input_current  output  OUT_WIDTH  signed result; held between done pulses
saturated  output  1  result was clipped; valid with done, held until next done

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulator, index and captured vectors 0. Reset is asynchronous and overrides everything.
- States:
  - IDLE: on start=1, capture input_spikes and weights into internal registers, clear the accumulator and index, then go to ACCUM.
  - ACCUM: acc += sum over lanes k of (spike[idx+k] ? sext(w[idx+k]) : 0), then idx += LANES. Go to DONE after the cycle with idx = M-LANES.
  - DONE: write input_current and saturated, pulse done for one cycle, then go to IDLE.
- Latency: start sampled at edge 0; ACCUM occupies edges 1..M/LANES; input_current and done are registered at edge M/LANES+1 (edge 7 for the defaults). busy is high from edge 1 through the DONE cycle.
- Start while busy (ACCUM or DONE) is ignored and not queued. start held high continuously gives back-to-back operations with one IDLE cycle between them.
- Input spikes and weights may change freely after the capture edge without affecting the result.
- Arithmetic: all weights are sign-extended to ACC_W and summed as signed values. The lane adder tree is combinational within one cycle.
- Output conversion:
  - acc > 2^(OUT_WIDTH-1)-1 → max positive, saturated=1.
  - acc < -2^(OUT_WIDTH-1) → min negative, saturated=1.
  - otherwise → acc[OUT_WIDTH-1:0], saturated=0.
- Reset asserted mid-ACCUM aborts the operation: no done pulse, outputs return to 0.

Optional Feature:
INPUT_CURRENT_SAT_EN
- Defined: saturating conversion exactly as specified in Behaviour.
- Undefined: legacy wrap behaviour. input_current = acc[OUT_WIDTH-1:0] (two's-complement truncation) and saturated is tied to 0. Timing and handshake are unchanged.

Decomposition:
- Shared package snn_pkg:
  - clog2 constant function
  - state encoding localparams ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2
  - default W_WIDTH and OUT_WIDTH constants shared with the membrane block
- One sub-module: sat_truncate (parameters IN_W, OUT_W). Combinational clip or wrap with a saturated flag; reused by the membrane update.

Test Plan:
All cases use defaults (M=24, LANES=4, W=8, OUT=8), with start pulsed at edge 0.
1. Spikes=0, arbitrary weights → busy high edges 1-7, done at edge 7, input_current=0, saturated=0.
2. Spikes at bits 0, 5, 23 with weights +10, -3, +20, all other weights 0x7F → input_current=27, saturated=0.
3. All spikes set, all weights +100 (sum 2400):
   - with SAT_EN → input_current=127 (0x7F), saturated=1
   - without SAT_EN → 96 (0x60), saturated=0
4. All spikes set, all weights -128 (sum -3072):
   - with SAT_EN → input_current=-128 (0x80), saturated=1
   - without SAT_EN → 0x00
5. Start the case-2 vectors, then at edge 2 change the vectors and pulse start again → a single done with value 27 only, no second operation. A new start after done gives the new result.
6. Assert reset at edge 3 of an ACCUM → outputs 0 immediately and no done. After release, a case-2 start completes normally with 27.
